ram_burst_reader: RTL and testbench

Read-side initiator for the team's single-port-pair `ram` block. It accepts a burst command (base address, stride, word count) and issues one RAM read request per cycle. It tracks the RAM's fixed 2-cycle read latency and returns the words on a valid/ready stream through an internal credit-managed FIFO, so downstream backpressure never loses data. It sits between the RAM bank and PE/stream consumers.

---
 rtl/ram_burst_reader_pkg.sv | 16 +
 rtl/ram_reader_fifo.sv | 81 ++++++++
 rtl/ram_burst_reader.sv | 155 +++++++++++++++
 tb/tb_ram_burst_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared types and constants for the RAM burst reader and its return FIFO.
// Optional stall counter is enabled by defining RAM_BURST_READER_STALL_CNT_EN.
package ram_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int RAM_RD_LATENCY = 2;

    // Requests live from the issue edge until the FIFO write, i.e. latency + 1 cycles.
    localparam int INFLIGHT_WIDTH = $clog2(RAM_RD_LATENCY + 2);

endpackage

// File: rtl/ram_reader_fifo.sv
// Return buffer for the burst reader: the head entry lives in a register that
// drives the stream outputs directly, the rest sits in a small memory.
module ram_reader_fifo
    import ram_burst_reader_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   mem_count;

    logic take;
    logic load_mem;
    logic bypass;
    logic mem_wr;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        take     = 1'b0;
        load_mem = 1'b0;
        bypass   = 1'b0;
        mem_wr   = 1'b0;
        take     = !out_valid || pop;
        load_mem = take && (mem_count != '0);
        bypass   = take && (mem_count == '0) && push;
        mem_wr   = push && !bypass;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (mem_wr)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (load_mem)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({mem_wr, load_mem})
                2'b10:   mem_count <= mem_count + CNT_ONE;
                2'b01:   mem_count <= mem_count - CNT_ONE;
                default: mem_count <= mem_count;
            endcase
            if (take) begin
                out_valid <= load_mem || bypass;
                if (load_mem)
                    out_data <= mem[rd_ptr];
                else if (bypass)
                    out_data <= push_data;
            end
        end
    end

    // NOTE: storage is not reset; the pointers and counts alone define which entries are live.
    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[wr_ptr] <= push_data;
    end

    assign count = mem_count + {{PTR_W{1'b0}}, out_valid};

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: issues strided RAM reads under FIFO credit control and
// streams returned words out. Define RAM_BURST_READER_STALL_CNT_EN for stall_cycles.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [ADDR_WIDTH:0]   cfg_num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  s_read_req,
    output logic [ADDR_WIDTH-1:0] s_read_addr,
    input  logic [DATA_WIDTH-1:0] s_read_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
`ifdef RAM_BURST_READER_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0]       WORD_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [INFLIGHT_WIDTH-1:0] INFLIGHT_ONE = {{(INFLIGHT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0]     stride_q;
    logic [ADDR_WIDTH:0]       issue_rem;
    logic [ADDR_WIDTH:0]       cap_rem;
    logic                      zero_burst;
    logic [INFLIGHT_WIDTH-1:0] inflight;
    logic [RAM_RD_LATENCY-1:0] rd_pipe;

    logic                      start_ok;
    logic                      issue;
    logic                      capture;
    logic                      capture_last;
    logic                      last_pop;
    logic                      credit_ok;
    logic [CNT_W-1:0]          fifo_count;
    logic [DATA_WIDTH:0]       fifo_out;

    assign busy         = (state != ST_IDLE);
    assign start_ok     = (state == ST_IDLE) && cfg_start;
    assign capture      = rd_pipe[RAM_RD_LATENCY-1];
    assign capture_last = capture && (cap_rem == WORD_ONE);
    assign last_pop     = m_valid && m_ready && m_last;
    assign credit_ok    = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);

    // The first request is decided in the accepting IDLE cycle so it reaches the RAM one cycle after start.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    issue      = (cfg_num_words != '0);
                    state_next = (cfg_num_words <= WORD_ONE) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_rem == WORD_ONE)
                        state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (zero_burst || last_pop)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            stride_q    <= '0;
            issue_rem   <= '0;
            cap_rem     <= '0;
            zero_burst  <= 1'b0;
            inflight    <= '0;
            rd_pipe     <= '0;
            s_read_req  <= 1'b0;
            s_read_addr <= '0;
            done        <= 1'b0;
        end else begin
            state      <= state_next;
            s_read_req <= issue;
            done       <= (start_ok && (cfg_num_words == '0)) || ((state == ST_DRAIN) && last_pop);
            rd_pipe    <= {rd_pipe[RAM_RD_LATENCY-2:0], s_read_req};

            if (start_ok) begin
                stride_q    <= cfg_stride;
                issue_rem   <= cfg_num_words - WORD_ONE;
                cap_rem     <= cfg_num_words;
                zero_burst  <= (cfg_num_words == '0);
                s_read_addr <= cfg_base_addr;
            end else begin
                if (issue) begin
                    s_read_addr <= s_read_addr + stride_q;
                    issue_rem   <= issue_rem - WORD_ONE;
                end
                if (capture)
                    cap_rem <= cap_rem - WORD_ONE;
            end

            case ({issue, capture})
                2'b10:   inflight <= inflight + INFLIGHT_ONE;
                2'b01:   inflight <= inflight - INFLIGHT_ONE;
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef RAM_BURST_READER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || start_ok)
            stall_cycles <= '0;
        else if ((state == ST_ISSUE) && !credit_ok && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

    // The side bit carries the end-of-burst tag alongside each word.
    ram_reader_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data ({capture_last, s_read_data}),
        .pop       (m_ready),
        .out_data  (fifo_out),
        .out_valid (m_valid),
        .count     (fifo_count)
    );

    assign m_last = fifo_out[DATA_WIDTH];
    assign m_data = fifo_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: RAM model with mem[a] = a, queue-based
// reference of the request and stream sequences, randomized backpressure.
module tb_ram_burst_reader;

    localparam int DW    = 10;
    localparam int AW    = 12;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic          cfg_start;
    logic [AW-1:0] cfg_base_addr;
    logic [AW-1:0] cfg_stride;
    logic [AW:0]   cfg_num_words;
    logic          busy;
    logic          done;
    logic          s_read_req;
    logic [AW-1:0] s_read_addr;
    logic [DW-1:0] s_read_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
`ifdef RAM_BURST_READER_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    ram_burst_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_stride    (cfg_stride),
        .cfg_num_words (cfg_num_words),
        .busy          (busy),
        .done          (done),
        .s_read_req    (s_read_req),
        .s_read_addr   (s_read_addr),
        .s_read_data   (s_read_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready)
`ifdef RAM_BURST_READER_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM: request sampled at one edge, data presented after the next, held otherwise.
    logic          rd_v;
    logic [AW-1:0] rd_a;
    always @(posedge clk) begin
        if (reset) begin
            rd_v        <= 1'b0;
            rd_a        <= '0;
            s_read_data <= '0;
        end else begin
            rd_v <= s_read_req;
            rd_a <= s_read_addr;
            if (rd_v)
                s_read_data <= rd_a[DW-1:0];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: expected request addresses and stream words of the current burst.
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic [AW-1:0] addr_q[$];
    word_t         exp_q[$];
    logic [AW-1:0] req_log[$];
    logic [DW-1:0] got_log[$];
    logic          last_log[$];
    int            hs_cyc_log[$];
    int            exp_done_cyc = -1;
    int            issued = 0;
    int            popped = 0;

    task automatic plan_burst(input int base, input int stride, input int n);
        for (int i = 0; i < n; i++) begin
            int a;
            word_t w;
            a = (base + i * stride) % (1 << AW);
            addr_q.push_back(AW'(a));
            w.data = DW'(a % (1 << DW));
            w.last = (i == n - 1);
            exp_q.push_back(w);
        end
        if (n == 0)
            exp_done_cyc = cyc + 1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        got_log.delete();
        last_log.delete();
        hs_cyc_log.delete();
    endtask

    // Per-cycle comparison of DUT outputs against the model, sampled on the falling edge.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            addr_q.delete();
            exp_q.delete();
            exp_done_cyc = -1;
            issued       = 0;
            popped       = 0;
            prev_stall   = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (s_read_req) begin
                check("credit_limit", (issued - popped) < DEPTH, 1'b1);
                if (addr_q.size() == 0)
                    check("spurious_req", s_read_req, 1'b0);
                else
                    check("req_addr", s_read_addr, addr_q.pop_front());
                req_log.push_back(s_read_addr);
                issued++;
            end
            if (m_valid && exp_q.size() == 0)
                check("spurious_valid", m_valid, 1'b0);
            else if (m_valid && m_ready) begin
                word_t w;
                w = exp_q.pop_front();
                check("stream_data", m_data, w.data);
                check("stream_last", m_last, w.last);
                got_log.push_back(m_data);
                last_log.push_back(m_last);
                hs_cyc_log.push_back(cyc);
                popped++;
                if (m_last)
                    exp_done_cyc = cyc + 1;
            end
            if (done || cyc == exp_done_cyc)
                check("done_timing", done, cyc == exp_done_cyc);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // 0: ready held high, 1: ready low ~30% of cycles, 2: ready held low.
    int ready_mode = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            1:       m_ready = ($urandom_range(99) >= 30);
            2:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
    endtask

    task automatic start_burst(input int base, input int stride, input int n);
        clear_logs();
        cfg_start     = 1'b1;
        cfg_base_addr = AW'(base);
        cfg_stride    = AW'(stride);
        cfg_num_words = (AW + 1)'(n);
        plan_burst(base, stride, n);
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done)
                seen = 1'b1;
            else
                tick();
        end
        check(name, seen, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int busy_cnt;
        int valid_cnt;

        reset         = 1'b1;
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_stride    = '0;
        cfg_num_words = '0;
        m_ready       = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", s_read_req, 1'b0);
        check("rst_addr", s_read_addr, '0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_last", m_last, 1'b0);
        check("rst_data", m_data, '0);
        reset = 1'b0;
        tick();

        // Basic burst with first-word latency.
        start_burst(12'h010, 1, 4);
        lat = 1;
        while (!m_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("first_latency", lat, 4);
        wait_done("t1_done", 100);
        check("t1_count", got_log.size(), 4);
        if (got_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check("t1_word", got_log[i], 10'h010 + i);
            check("t1_last_tag", last_log[3], 1'b1);
        end

        // Start the cycle after done, with address wrap.
        tick();
        start_burst(12'hFFE, 1, 4);
        wait_done("t2_done", 100);
        check("t2_req_count", req_log.size(), 4);
        if (req_log.size() == 4) begin
            check("t2_addr0", req_log[0], 12'hFFE);
            check("t2_addr1", req_log[1], 12'hFFF);
            check("t2_addr2", req_log[2], 12'h000);
            check("t2_addr3", req_log[3], 12'h001);
        end

        // Stride 3 under random backpressure.
        tick();
        ready_mode = 1;
        start_burst(int'($urandom_range(4095)), 3, 16);
        wait_done("t3_done", 400);
        check("t3_count", got_log.size(), 16);

        // Random bursts, random ready behaviour.
        for (int k = 0; k < 5; k++) begin
            tick();
            ready_mode = int'($urandom_range(1));
            start_burst(int'($urandom_range(4095)), int'($urandom_range(4095)), int'($urandom_range(1, 20)));
            wait_done("rand_done", 400);
        end

        // Full throughput with ready held high.
        ready_mode = 0;
        tick();
        start_burst(12'h300, 2, 12);
        wait_done("t4_done", 100);
        check("t4_count", hs_cyc_log.size(), 12);
        if (hs_cyc_log.size() == 12)
            check("t4_back_to_back", hs_cyc_log[11] - hs_cyc_log[0], 11);

        // Zero-length burst.
        tick();
        start_burst(12'h123, 1, 0);
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            busy_cnt += int'(busy);
            tick();
        end
        check("t5_busy_cycles", busy_cnt, 1);
        check("t5_no_req", req_log.size(), 0);

        // Reset two cycles after the fourth request of a 10-word burst.
        tick();
        start_burst(12'h100, 1, 10);
        for (int i = 0; i < 5; i++)
            tick();
        reset = 1'b1;
        tick();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_req", s_read_req, 1'b0);
        check("mid_rst_addr", s_read_addr, '0);
        check("mid_rst_valid", m_valid, 1'b0);
        check("mid_rst_last", m_last, 1'b0);
        check("mid_rst_data", m_data, '0);
        reset = 1'b0;
        valid_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            valid_cnt += int'(m_valid);
        end
        check("post_rst_no_valid", valid_cnt, 0);
        start_burst(12'h200, 5, 2);
        wait_done("t6_done", 100);
        check("t6_count", got_log.size(), 2);
        if (got_log.size() == 2) begin
            check("t6_word0", got_log[0], 10'h200);
            check("t6_word1", got_log[1], 10'h205);
        end

`ifdef RAM_BURST_READER_STALL_CNT_EN
        // Ready low for 20 cycles starting with the start cycle.
        tick();
        ready_mode = 2;
        tick();
        start_burst(12'h040, 2, 12);
        for (int i = 0; i < 18; i++)
            tick();
        ready_mode = 0;
        tick();
        wait_done("t7_done", 200);
        check("stall_cycles", stall_cycles, 32'd13);
        tick();
        start_burst(12'h050, 1, 2);
        check("stall_clear_on_start", stall_cycles, 32'd0);
        wait_done("t8_done", 100);
`endif

        for (int i = 0; i < 4; i++)
            tick();
        check("model_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
